vga_render_pipe: RTL and testbench

- Pipelined, parametrised pixel renderer. It is the registered successor to the combinational screen-colour stage, placed between game_logic and the VGA timing/DAC output.
- Snapshots the game state once per frame so a frame never mixes two game states (no tearing).
- Renders the player, up to N_OBS obstacles and a mode-dependent background with a fixed 2-cycle latency.
- Adds pause-mode player blink, overlap highlighting and a per-frame collision flag reported back to game logic.

---
 rtl/vga_render_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_vga_render_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_render_pipe.sv
// Two-stage pixel renderer: per-frame game-state snapshot, hit detection in
// stage 1, colour selection and collision accumulation in stage 2.
module vga_render_pipe #(
  parameter int N_OBS        = 10,
  parameter int X_W          = 10,
  parameter int Y_W          = 9,
  parameter int PLAYER_X     = 160,
  parameter int PLAYER_SIZE  = 40,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   pix_valid,
  input  logic [X_W-1:0]         pix_x,
  input  logic [Y_W-1:0]         pix_y,
  input  logic [1:0]             gamemode,
  input  logic [Y_W-1:0]         player_y,
  input  logic [N_OBS*2*X_W-1:0] obstacle_x,
  input  logic [N_OBS*2*Y_W-1:0] obstacle_y,
  output logic [7:0]             rgb,
  output logic                   rgb_valid,
  output logic                   collide_out
);

  typedef enum logic [1:0] {
    MODE_INIT  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_PAUSE = 2'b10,
    MODE_OVER  = 2'b11
  } mode_e;

  localparam logic [7:0] COL_BLANK      = 8'b000_000_00;
  localparam logic [7:0] COL_OVERLAP    = 8'b111_000_11;
  localparam logic [7:0] COL_PLAYER     = 8'b000_000_11;
  localparam logic [7:0] COL_PLAYER_END = 8'b111_111_11;
  localparam logic [7:0] COL_OBSTACLE   = 8'b111_011_00;
  localparam logic [7:0] COL_BG_INIT    = 8'b110_110_11;
  localparam logic [7:0] COL_BG_RUN     = 8'b000_111_00;
  localparam logic [7:0] COL_BG_PAUSE   = 8'b111_111_00;
  localparam logic [7:0] COL_BG_OVER    = 8'b111_000_00;

  localparam int BW = $clog2(2 * BLINK_FRAMES);
  localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_FRAMES - 1);

  // One extra bit on every player bound so the bottom/right edge cannot wrap.
  localparam logic [X_W:0] PX_LO = (X_W + 1)'(PLAYER_X);
  localparam logic [X_W:0] PX_HI = (X_W + 1)'(PLAYER_X + PLAYER_SIZE);
  localparam logic [Y_W:0] PSIZE = (Y_W + 1)'(PLAYER_SIZE);

  // ---------------------------------------------------------------- snapshot
  mode_e                  mode_q;
  logic [Y_W-1:0]         py_q;
  logic [N_OBS*2*X_W-1:0] obs_x_q;
  logic [N_OBS*2*Y_W-1:0] obs_y_q;
  logic [BW-1:0]          blink_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_INIT;
      py_q    <= '0;
      obs_x_q <= '0;
      obs_y_q <= '0;
    end else if (frame_start) begin
      mode_q  <= mode_e'(gamemode);
      py_q    <= player_y;
      obs_x_q <= obstacle_x;
      obs_y_q <= obstacle_y;
    end
  end

  // Blink phase advances only across consecutive paused frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q <= '0;
    end else if (frame_start) begin
      if (mode_e'(gamemode) != MODE_PAUSE) begin
        blink_q <= '0;
      end else if (mode_q == MODE_PAUSE) begin
        blink_q <= (blink_q == BLINK_LAST) ? '0 : blink_q + BW'(1);
      end
    end
  end

  // ------------------------------------------------------ stage 1 hit logic
  logic [X_W:0]     x_ext;
  logic [Y_W:0]     y_ext;
  logic [Y_W:0]     py_lo;
  logic [Y_W:0]     py_hi;
  logic             player_hit;
  logic             player_hide;
  logic [N_OBS-1:0] obs_hit;

  assign x_ext = {1'b0, pix_x};
  assign y_ext = {1'b0, pix_y};
  assign py_lo = {1'b0, py_q};
  assign py_hi = py_lo + PSIZE;

  assign player_hit = (x_ext >= PX_LO) && (x_ext < PX_HI) &&
                      (y_ext >= py_lo) && (y_ext < py_hi);

  assign player_hide = (mode_q == MODE_PAUSE) && (blink_q >= BLINK_HALF);

  for (genvar g = 0; g < N_OBS; g++) begin : g_obs
    logic [X_W-1:0] left;
    logic [X_W-1:0] right;
    logic [Y_W-1:0] top;
    logic [Y_W-1:0] bottom;
    logic           enabled;

    assign left    = obs_x_q[g*2*X_W +: X_W];
    assign right   = obs_x_q[g*2*X_W+X_W +: X_W];
    assign top     = obs_y_q[g*2*Y_W +: Y_W];
    assign bottom  = obs_y_q[g*2*Y_W+Y_W +: Y_W];
    assign enabled = !((left == right) && (top == bottom));

    // Half-open bounds: inverted or zero-width boxes never match.
    assign obs_hit[g] = enabled &&
                        (pix_x >= left) && (pix_x < right) &&
                        (pix_y >= top)  && (pix_y < bottom);
  end

  logic             v1;
  logic             phit1;
  logic             hide1;
  mode_e            mode1;
  logic [N_OBS-1:0] ohit1;

  // Mode and blink state travel with the pixel so a snapshot landing while
  // a pixel is in flight cannot change that pixel's colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      phit1 <= 1'b0;
      hide1 <= 1'b0;
      mode1 <= MODE_INIT;
      ohit1 <= '0;
    end else begin
      v1    <= pix_valid;
      phit1 <= player_hit;
      hide1 <= player_hide;
      mode1 <= mode_q;
      ohit1 <= obs_hit;
    end
  end

  // ---------------------------------------------------- stage 2 colour mux
  logic       player_vis;
  logic       any_obs;
  logic       overlap;
  logic [7:0] colour;

  assign player_vis = phit1 && !hide1;
  assign any_obs    = |ohit1;
  assign overlap    = v1 && player_vis && any_obs;

  // NOTE: colour gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    colour = COL_BLANK;
    if (!v1) begin
      colour = COL_BLANK;
    end else if (player_vis && any_obs) begin
      colour = COL_OVERLAP;
    end else if (player_vis) begin
      colour = (mode1 == MODE_OVER) ? COL_PLAYER_END : COL_PLAYER;
    end else if (any_obs) begin
      colour = COL_OBSTACLE;
    end else begin
      unique case (mode1)
        MODE_INIT:  colour = COL_BG_INIT;
        MODE_RUN:   colour = COL_BG_RUN;
        MODE_PAUSE: colour = COL_BG_PAUSE;
        MODE_OVER:  colour = COL_BG_OVER;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb       <= COL_BLANK;
      rgb_valid <= 1'b0;
    end else begin
      rgb       <= colour;
      rgb_valid <= v1;
    end
  end

  // ---------------------------------------------------- collision tracking
  logic collide_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      collide_acc <= 1'b0;
      collide_out <= 1'b0;
    end else if (frame_start) begin
      collide_out <= collide_acc | overlap;
      collide_acc <= 1'b0;
    end else begin
      collide_acc <= collide_acc | overlap;
    end
  end

endmodule

// File: tb/tb_vga_render_pipe.sv
// Scoreboard bench for vga_render_pipe: expected colours are queued as pixels
// are driven and matched, with their 2-cycle latency, as rgb_valid appears.
module tb_vga_render_pipe;

  localparam int N_OBS = 10;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int BLINK = 2;

  localparam logic [7:0] C_OVERLAP = 8'hE3;
  localparam logic [7:0] C_PLAYER  = 8'h03;
  localparam logic [7:0] C_PL_OVER = 8'hFF;
  localparam logic [7:0] C_OBST    = 8'hEC;
  localparam logic [7:0] C_BG_INIT = 8'hDB;
  localparam logic [7:0] C_BG_RUN  = 8'h1C;
  localparam logic [7:0] C_BG_PAUS = 8'hFC;
  localparam logic [7:0] C_BG_OVER = 8'hE0;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   frame_start = 1'b0;
  logic                   pix_valid = 1'b0;
  logic [X_W-1:0]         pix_x = '0;
  logic [Y_W-1:0]         pix_y = '0;
  logic [1:0]             gamemode = 2'b00;
  logic [Y_W-1:0]         player_y = '0;
  logic [N_OBS*2*X_W-1:0] obstacle_x = '0;
  logic [N_OBS*2*Y_W-1:0] obstacle_y = '0;
  logic [7:0]             rgb;
  logic                   rgb_valid;
  logic                   collide_out;

  vga_render_pipe #(
    .N_OBS(N_OBS), .X_W(X_W), .Y_W(Y_W),
    .PLAYER_X(160), .PLAYER_SIZE(40), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .gamemode(gamemode), .player_y(player_y),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .rgb(rgb), .rgb_valid(rgb_valid), .collide_out(collide_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rgb;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc++;

  // Output monitor: every valid pixel must match the queue head and arrive
  // exactly two clock edges after it was driven; blanking must be 0x00.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      checks++;
      if (rgb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: rgb_valid=1 rgb=%h at cycle %0d, required no output",
                   rgb, cyc);
        end else begin
          e = sb.pop_front();
          if (rgb !== e.rgb || cyc !== e.cyc + 2) begin
            errors++;
            $display("FAIL pixel: rgb=%h at cycle %0d, required %h at cycle %0d",
                     rgb, cyc, e.rgb, e.cyc + 2);
          end
        end
      end else if (rgb_valid !== 1'b0 || rgb !== 8'h00) begin
        errors++;
        $display("FAIL blanking: rgb_valid=%b rgb=%h, required 0 and 00", rgb_valid, rgb);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pix(input int x, input int y, input logic [7:0] e);
    pix_valid = 1'b1;
    pix_x     = X_W'(x);
    pix_y     = Y_W'(y);
    sb.push_back('{rgb: e, cyc: cyc});
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic frame(input logic [1:0] m, input int py);
    gamemode    = m;
    player_y    = Y_W'(py);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic set_slot(input int i, input int l, input int r, input int t, input int b);
    obstacle_x[i*2*X_W +: X_W]     = X_W'(l);
    obstacle_x[i*2*X_W+X_W +: X_W] = X_W'(r);
    obstacle_y[i*2*Y_W +: Y_W]     = Y_W'(t);
    obstacle_y[i*2*Y_W+Y_W +: Y_W] = Y_W'(b);
  endtask

  task automatic clear_slots();
    obstacle_x = '0;
    obstacle_y = '0;
  endtask

  task automatic check_collide(input string name, input logic exp);
    checks++;
    if (collide_out !== exp) begin
      errors++;
      $display("FAIL %s: collide_out=%b, required %b", name, collide_out, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    mon_en = 1'b1;
    tick();
    check_collide("reset_collide", 1'b0);
    rst = 1'b0;
    pix(0, 0, C_BG_INIT);
    idle(3);
    // Pixel caught in stage 1 by a reset must never reach the output.
    pix_valid = 1'b1;
    pix_x     = 10'd5;
    pix_y     = 9'd5;
    tick();
    rst       = 1'b1;
    pix_valid = 1'b0;
    tick();
    rst = 1'b0;
    idle(3);
    pix(0, 0, C_BG_INIT);
    idle(3);
    // Reset beats a simultaneous snapshot.
    rst         = 1'b1;
    gamemode    = 2'b01;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    rst         = 1'b0;
    pix(0, 0, C_BG_INIT);
    idle(3);
  endtask

  task automatic test_basic();
    clear_slots();
    set_slot(0, 300, 320, 50, 60);
    frame(2'b01, 100);
    pix(160, 100, C_PLAYER);
    pix(199, 139, C_PLAYER);
    pix(200, 139, C_BG_RUN);
    pix(300, 50, C_OBST);
    pix(320, 50, C_BG_RUN);
    pix(319, 59, C_OBST);
    pix(300, 60, C_BG_RUN);
    pix(159, 100, C_BG_RUN);
    pix(160, 99, C_BG_RUN);
    pix(160, 140, C_BG_RUN);
    idle(3);
  endtask

  task automatic test_disabled();
    set_slot(3, 200, 200, 120, 120);
    set_slot(4, 200, 200, 110, 130);
    set_slot(5, 250, 240, 10, 20);
    frame(2'b01, 100);
    pix(200, 120, C_BG_RUN);
    pix(200, 125, C_BG_RUN);
    pix(199, 120, C_PLAYER);
    pix(245, 15, C_BG_RUN);
    idle(3);
  endtask

  task automatic test_collide();
    clear_slots();
    set_slot(1, 170, 180, 110, 120);
    frame(2'b01, 100);
    check_collide("collide_clear", 1'b0);
    pix(175, 115, C_OVERLAP);
    pix(185, 115, C_PLAYER);
    pix(175, 125, C_PLAYER);
    idle(3);
    check_collide("collide_hold", 1'b0);
    frame(2'b01, 100);
    check_collide("collide_set", 1'b1);
    idle(2);
    frame(2'b01, 100);
    check_collide("collide_drop", 1'b0);
    // Overlap sitting in stage 2 on the frame_start cycle itself.
    pix(172, 111, C_OVERLAP);
    frame(2'b01, 100);
    check_collide("collide_same_cycle", 1'b1);
    idle(3);
    frame(2'b01, 100);
    check_collide("collide_same_cycle_drop", 1'b0);
  endtask

  task automatic test_blink();
    clear_slots();
    for (int f = 0; f < 5; f++) begin
      frame(2'b10, 100);
      pix(170, 110, (f == 2 || f == 3) ? C_BG_PAUS : C_PLAYER);
      pix(0, 0, C_BG_PAUS);
      idle(3);
    end
    frame(2'b01, 100);
  endtask

  task automatic test_snapshot();
    clear_slots();
    frame(2'b01, 100);
    player_y = 9'd300;
    gamemode = 2'b11;
    pix(170, 110, C_PLAYER);
    pix(170, 310, C_BG_RUN);
    pix(0, 0, C_BG_RUN);
    // Pixel entering stage 1 with frame_start still sees the old snapshot.
    gamemode    = 2'b01;
    pix_valid   = 1'b1;
    pix_x       = 10'd170;
    pix_y       = 9'd110;
    sb.push_back('{rgb: C_PLAYER, cyc: cyc});
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix(170, 310, C_PLAYER);
    pix(170, 110, C_BG_RUN);
    idle(3);
  endtask

  task automatic test_modes();
    clear_slots();
    set_slot(0, 300, 320, 50, 60);
    frame(2'b11, 100);
    pix(170, 110, C_PL_OVER);
    pix(0, 0, C_BG_OVER);
    pix(305, 55, C_OBST);
    frame(2'b00, 100);
    pix(0, 0, C_BG_INIT);
    pix(170, 110, C_PLAYER);
    frame(2'b10, 100);
    pix(170, 110, C_PLAYER);
    pix(0, 0, C_BG_PAUS);
    frame(2'b01, 480);
    pix(170, 505, C_PLAYER);
    pix(170, 479, C_BG_RUN);
    pix(170, 511, C_PLAYER);
    pix(170, 5, C_BG_RUN);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_disabled();
    test_collide();
    test_blink();
    test_snapshot();
    test_modes();
    idle(5);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pixels outstanding, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
